// File: rtl/pipe_field_if.sv
// rtl/pipe_field_if.sv - control inputs and flattened pipe coordinate outputs of pipe_field
interface pipe_field_if #(
    parameter int NUM_PIPES = 2,
    parameter int COORD_W   = 10
);
    logic                           Enable;
    logic                           Restart;
    logic [1:0]                     SpeedSel;
    logic [COORD_W-1:0]             BirdX;
    logic [NUM_PIPES*COORD_W-1:0]   PipeX;
    logic [NUM_PIPES*COORD_W-1:0]   PipeY;
    logic                           Passed;
    logic                           Running;

    modport master (
        output Enable, Restart, SpeedSel, BirdX,
        input  PipeX, PipeY, Passed, Running
    );

    modport slave (
        input  Enable, Restart, SpeedSel, BirdX,
        output PipeX, PipeY, Passed, Running
    );
endinterface

// File: rtl/pipe_field.sv
// rtl/pipe_field.sv - scrolling pipe obstacle generator with LFSR gap heights and score pulse
module pipe_field #(
    parameter int          NUM_PIPES    = 2,
    parameter int          COORD_W      = 10,
    parameter int          SCREEN_W     = 640,
    parameter int          PIPE_W       = 60,
    parameter int          PIPE_SPACING = 320,
    parameter int          TICK_DIV     = 500000,
    parameter int          GAP_MIN      = 100,
    parameter int          GAP_MAX      = 380,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic           Clk,
    input  logic           Reset,
    pipe_field_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int XW    = NUM_PIPES * COORD_W;

    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [COORD_W:0]   PW_E     = (COORD_W+1)'(PIPE_W);
    localparam logic [COORD_W:0]   SPAN_E   = (COORD_W+1)'(NUM_PIPES * PIPE_SPACING);
    localparam logic [9:0]         GAP_R    = 10'(GAP_MAX - GAP_MIN);
    localparam logic [COORD_W-1:0] GAP_MID  = COORD_W'((GAP_MIN + GAP_MAX) / 2);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [XW-1:0]    pipe_x_q, pipe_x_d;
    logic [XW-1:0]    pipe_y_q, pipe_y_d;
    logic             passed_q, passed_d;
    logic             running_q, running_d;
    logic             tick;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // Nine LFSR bits folded once into the gap range, clamped as a safety net
    function automatic logic [COORD_W-1:0] fold_gap(input logic [15:0] l);
        logic [9:0] off;
        off = {1'b0, l[8:0]};
        if (off > GAP_R) off = off - GAP_R - 10'd1;
        if (off > GAP_R) off = GAP_R;
        return COORD_W'(GAP_MIN) + COORD_W'(off);
    endfunction

    function automatic logic [XW-1:0] x_init();
        logic [XW-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_PIPES; i++)
            v[i*COORD_W +: COORD_W] = COORD_W'(SCREEN_W + i * PIPE_SPACING);
        return v;
    endfunction

    function automatic logic [XW-1:0] y_init();
        logic [XW-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_PIPES; i++)
            v[i*COORD_W +: COORD_W] = GAP_MID;
        return v;
    endfunction

    assign tick = (state_q == RUN) && (div_q == DIV_LAST);

    always_comb begin
        logic [COORD_W:0] step;
        logic [COORD_W:0] bird;
        logic [COORD_W:0] x_old;
        logic [COORD_W:0] x_new;
        logic [15:0]      lfsr_v;
        logic             wrap;
        logic             score;

        state_d   = state_q;
        div_d     = div_q;
        lfsr_d    = lfsr_q;
        pipe_x_d  = pipe_x_q;
        pipe_y_d  = pipe_y_q;
        passed_d  = 1'b0;
        step      = (COORD_W+1)'(bus.SpeedSel) + (COORD_W+1)'(1);
        bird      = {1'b0, bus.BirdX};
        x_old     = '0;
        x_new     = '0;
        lfsr_v    = lfsr_q;
        wrap      = 1'b0;
        score     = 1'b0;

        case (state_q)
            IDLE:    if (bus.Enable)  state_d = RUN;
            RUN:     if (!bus.Enable) state_d = HOLD;
            HOLD:    if (bus.Enable)  state_d = RUN;
            default: state_d = IDLE;
        endcase

        if (state_q == RUN)
            div_d = tick ? '0 : div_q + DIV_W'(1);

        // Each wrapping channel consumes its own LFSR state, lowest index first
        if (tick) begin
            for (int i = 0; i < NUM_PIPES; i++) begin
                x_old = {1'b0, pipe_x_q[i*COORD_W +: COORD_W]};
                wrap  = !(x_old > step);
                if (wrap) begin
                    x_new  = x_old + SPAN_E - step;
                    lfsr_v = lfsr_step(lfsr_v);
                    pipe_y_d[i*COORD_W +: COORD_W] = fold_gap(lfsr_v);
                end else begin
                    x_new = x_old - step;
                end
                pipe_x_d[i*COORD_W +: COORD_W] = x_new[COORD_W-1:0];
                if (!wrap && (x_old + PW_E >= bird) && (x_new + PW_E < bird))
                    score = 1'b1;
            end
            lfsr_d   = lfsr_v;
            passed_d = score;
        end

        if (bus.Restart) begin
            state_d  = IDLE;
            div_d    = '0;
            lfsr_d   = lfsr_q;
            pipe_x_d = x_init();
            pipe_y_d = y_init();
            passed_d = 1'b0;
        end

        running_d = (state_d == RUN);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            div_q     <= '0;
            lfsr_q    <= LFSR_SEED;
            pipe_x_q  <= x_init();
            pipe_y_q  <= y_init();
            passed_q  <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            lfsr_q    <= lfsr_d;
            pipe_x_q  <= pipe_x_d;
            pipe_y_q  <= pipe_y_d;
            passed_q  <= passed_d;
            running_q <= running_d;
        end
    end

    assign bus.PipeX   = pipe_x_q;
    assign bus.PipeY   = pipe_y_q;
    assign bus.Passed  = passed_q;
    assign bus.Running = running_q;
endmodule

// File: tb/tb_pipe_field.sv
// tb/tb_pipe_field.sv - directed vector bench for pipe_field with TICK_DIV=4
module tb_pipe_field;
    logic Clk = 1'b0;
    logic Reset = 1'b1;

    pipe_field_if #(.NUM_PIPES(2), .COORD_W(10)) bus ();

    pipe_field #(.TICK_DIV(4)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic       en;
        logic [1:0] sp;
        logic [9:0] bx;
        int         cyc;
        int         x0;
        int         x1;
        logic       run;
    } vec_t;

    vec_t        tbl[8];
    int          vec_cnt = 0;
    int          miss_cnt = 0;
    int          pulse_cnt = 0;
    logic [15:0] m_lfsr;
    int          exp_y0;

    wire [9:0] x0 = bus.PipeX[9:0];
    wire [9:0] x1 = bus.PipeX[19:10];
    wire [9:0] y0 = bus.PipeY[9:0];
    wire [9:0] y1 = bus.PipeY[19:10];

    always @(negedge Clk)
        if (Reset) assert (x0 <= 10'd960 && x1 <= 10'd960) else $error("PipeX beyond spawn range");

    function automatic logic [15:0] m_next(input logic [15:0] l);
        logic fb;
        fb = l[15] ^ l[13] ^ l[12] ^ l[10];
        return {l[14:0], fb};
    endfunction

    function automatic int m_fold(input logic [15:0] l);
        int off;
        off = int'(l[8:0]);
        if (off > 280) off = off - 281;
        if (off > 280) off = 280;
        return 100 + off;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge Clk);
            @(negedge Clk);
            if (bus.Passed) pulse_cnt++;
        end
    endtask

    initial begin
        bus.Enable = 1'b0; bus.Restart = 1'b0; bus.SpeedSel = 2'd0; bus.BirdX = 10'd0;

        //            en    sp    bx      cyc  x0   x1   run
        tbl[0] = '{1'b1, 2'd0, 10'd0,     1, 640, 960, 1'b1};
        tbl[1] = '{1'b1, 2'd0, 10'd0,     4, 639, 959, 1'b1};
        tbl[2] = '{1'b1, 2'd0, 10'd0,   156, 600, 920, 1'b1};
        tbl[3] = '{1'b1, 2'd3, 10'd0,     4, 596, 916, 1'b1};
        tbl[4] = '{1'b0, 2'd0, 10'd0,   100, 596, 916, 1'b0};
        tbl[5] = '{1'b1, 2'd0, 10'd0,     3, 596, 916, 1'b1};
        tbl[6] = '{1'b1, 2'd0, 10'd0,     1, 595, 915, 1'b1};
        tbl[7] = '{1'b1, 2'd1, 10'd100, 1108, 41, 361, 1'b1};

        #1 Reset = 1'b0;
        repeat (2) @(negedge Clk);
        check("rst_x0", x0, 640);
        check("rst_x1", x1, 960);
        check("rst_y0", y0, 240);
        check("rst_y1", y1, 240);
        check("rst_passed", bus.Passed, 0);
        check("rst_running", bus.Running, 0);
        Reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            bus.Enable   = tbl[i].en;
            bus.SpeedSel = tbl[i].sp;
            bus.BirdX    = tbl[i].bx;
            run(tbl[i].cyc);
            check($sformatf("vec%0d_x0", i), x0, tbl[i].x0);
            check($sformatf("vec%0d_x1", i), x1, tbl[i].x1);
            check($sformatf("vec%0d_running", i), bus.Running, tbl[i].run);
            check($sformatf("vec%0d_passed", i), bus.Passed, 0);
        end

        // Score window around BirdX=100 with step 1
        bus.SpeedSel = 2'd0;
        pulse_cnt = 0;
        run(4);
        check("score_x0_40", x0, 40);
        check("score_no_41_40", bus.Passed, 0);
        run(4);
        check("score_x0_39", x0, 39);
        check("score_40_39", bus.Passed, 1);
        run(1);
        check("score_one_cycle", bus.Passed, 0);
        run(3);
        check("score_x0_38", x0, 38);
        check("score_pulse_count", pulse_cnt, 1);

        // Wrap of pipe 0 with step 1
        run(148);
        check("prewrap_x0", x0, 1);
        check("prewrap_x1", x1, 321);
        run(4);
        m_lfsr = m_next(16'hACE1);
        exp_y0 = m_fold(m_lfsr);
        check("wrap_x0", x0, 640);
        check("wrap_x1", x1, 320);
        check("wrap_y0", y0, exp_y0);
        check("wrap_y1", y1, 240);
        check("wrap_y0_range", (y0 >= 10'd100 && y0 <= 10'd380), 1);

        // Restart returns to IDLE but leaves the LFSR running
        bus.Enable = 1'b0;
        bus.Restart = 1'b1;
        run(1);
        bus.Restart = 1'b0;
        check("restart_x0", x0, 640);
        check("restart_x1", x1, 960);
        check("restart_y0", y0, 240);
        check("restart_running", bus.Running, 0);
        run(3);
        check("restart_idle_x0", x0, 640);
        check("restart_idle_running", bus.Running, 0);

        bus.Enable = 1'b1;
        bus.SpeedSel = 2'd3;
        run(641);
        m_lfsr = m_next(m_lfsr);
        exp_y0 = m_fold(m_lfsr);
        check("wrap2_x0", x0, 640);
        check("wrap2_x1", x1, 320);
        check("wrap2_y0", y0, exp_y0);
        check("wrap2_running", bus.Running, 1);

        // Asynchronous reset between clock edges, mid divider count
        run(2);
        #2 Reset = 1'b0;
        #1;
        check("async_x0", x0, 640);
        check("async_x1", x1, 960);
        check("async_y0", y0, 240);
        check("async_running", bus.Running, 0);
        check("async_passed", bus.Passed, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end
endmodule
